// File: rtl/lr_writeback_sched_if.sv
// Handshake bundle between decode, the long-latency units, the register file and the scoreboard.
interface lr_writeback_sched_if #(
   parameter int XLEN = 64
);
   logic            issue_valid;
   logic            issue_unit;
   logic [4:0]      issue_rd;
   logic            issue_ready;
   logic            id_valid;
   logic [4:0]      id_rs1;
   logic [4:0]      id_rs2;
   logic            sb_stall;
   logic            md_done_valid;
   logic [4:0]      md_done_rd;
   logic [XLEN-1:0] md_done_data;
   logic            md_done_ready;
   logic            lsu_done_valid;
   logic [4:0]      lsu_done_rd;
   logic [XLEN-1:0] lsu_done_data;
   logic            lsu_done_ready;
   logic            pipe_wb_busy;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic [31:0]     reg_write_bitmap;

   modport master (
      output issue_valid, issue_unit, issue_rd, id_valid, id_rs1, id_rs2,
      output md_done_valid, md_done_rd, md_done_data,
      output lsu_done_valid, lsu_done_rd, lsu_done_data, pipe_wb_busy,
      input  issue_ready, sb_stall, md_done_ready, lsu_done_ready,
      input  wb_valid, wb_rd, wb_data, reg_write_bitmap
   );

   modport slave (
      input  issue_valid, issue_unit, issue_rd, id_valid, id_rs1, id_rs2,
      input  md_done_valid, md_done_rd, md_done_data,
      input  lsu_done_valid, lsu_done_rd, lsu_done_data, pipe_wb_busy,
      output issue_ready, sb_stall, md_done_ready, lsu_done_ready,
      output wb_valid, wb_rd, wb_data, reg_write_bitmap
   );
endinterface

// File: rtl/lr_writeback_sched.sv
// Scoreboard + long-latency writeback arbiter; SB_ROUND_ROBIN_EN gives round-robin, otherwise lsu beats muldiv.
// Issue->pending and grant->wb take 1 cycle; done_ready yields to pipe_wb_busy, issue_ready drops on pending rd or full unit.
module lr_writeback_sched #(
   parameter int XLEN        = 64,
   parameter int OUTSTANDING = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   lr_writeback_sched_if.slave  sb
);
   localparam int              CW      = $clog2(OUTSTANDING + 1);
   localparam logic [CW-1:0]   MAX_CNT = CW'(OUTSTANDING);

   logic [31:0]     pending;
   logic [31:0]     pending_nxt;
   logic [CW-1:0]   md_cnt;
   logic [CW-1:0]   lsu_cnt;
   logic            wb_valid_q;
   logic [4:0]      wb_rd_q;
   logic [XLEN-1:0] wb_data_q;
   logic            arb_en;
   logic            unit_has_room;
   logic            issue_fire;
   logic            grant_md;
   logic            grant_lsu;

   assign arb_en        = ~rst & ~sb.pipe_wb_busy;
   assign unit_has_room = sb.issue_unit ? (lsu_cnt < MAX_CNT) : (md_cnt < MAX_CNT);
   assign sb.issue_ready = ~rst & ~pending[sb.issue_rd] & unit_has_room;
   assign issue_fire    = sb.issue_valid & sb.issue_ready;
   assign sb.sb_stall   = sb.id_valid & (pending[sb.id_rs1] | pending[sb.id_rs2]);

   assign sb.reg_write_bitmap = pending;
   assign sb.md_done_ready    = grant_md;
   assign sb.lsu_done_ready   = grant_lsu;
   assign sb.wb_valid         = wb_valid_q;
   assign sb.wb_rd            = wb_rd_q;
   assign sb.wb_data          = wb_data_q;

`ifdef SB_ROUND_ROBIN_EN
   logic rr_ptr;

   always_comb begin
      grant_md  = 1'b0;
      grant_lsu = 1'b0;
      if (arb_en) begin
         if (sb.md_done_valid & sb.lsu_done_valid) begin
            grant_md  = ~rr_ptr;
            grant_lsu = rr_ptr;
         end else begin
            grant_md  = sb.md_done_valid;
            grant_lsu = sb.lsu_done_valid;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= 1'b0;
      end else if (grant_md) begin
         rr_ptr <= 1'b1;
      end else if (grant_lsu) begin
         rr_ptr <= 1'b0;
      end
   end
`else
   assign grant_lsu = arb_en & sb.lsu_done_valid;
   assign grant_md  = arb_en & sb.md_done_valid & ~sb.lsu_done_valid;
`endif

   // The bit being written back stays set through the wb cycle, so a same-rd issue is refused there.
   always_comb begin
      pending_nxt = pending;
      if (wb_valid_q) begin
         pending_nxt[wb_rd_q] = 1'b0;
      end
      if (issue_fire) begin
         pending_nxt[sb.issue_rd] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending    <= '0;
         md_cnt     <= '0;
         lsu_cnt    <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
      end else begin
         pending <= pending_nxt;
         md_cnt  <= md_cnt + CW'(issue_fire & ~sb.issue_unit) - CW'(grant_md);
         lsu_cnt <= lsu_cnt + CW'(issue_fire & sb.issue_unit) - CW'(grant_lsu);
         if (grant_lsu) begin
            wb_valid_q <= |sb.lsu_done_rd;
            wb_rd_q    <= sb.lsu_done_rd;
            wb_data_q  <= sb.lsu_done_data;
         end else if (grant_md) begin
            wb_valid_q <= |sb.md_done_rd;
            wb_rd_q    <= sb.md_done_rd;
            wb_data_q  <= sb.md_done_data;
         end else begin
            wb_valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_lr_writeback_sched.sv
// Bench for lr_writeback_sched: directed pins followed by randomized traffic against a queue-based model.
module tb_lr_writeback_sched;
   localparam int XLEN        = 64;
   localparam int OUTSTANDING = 2;

`ifdef SB_ROUND_ROBIN_EN
   localparam logic        FIRST_MD = 1'b1;
   localparam logic [4:0]  WB1_RD   = 5'd5;
   localparam logic [63:0] WB1_DATA = 64'h11;
   localparam logic [4:0]  WB2_RD   = 5'd7;
   localparam logic [63:0] WB2_DATA = 64'h22;
   localparam logic [31:0] BM_AFTER1 = 32'h0000_0080;
`else
   localparam logic        FIRST_MD = 1'b0;
   localparam logic [4:0]  WB1_RD   = 5'd7;
   localparam logic [63:0] WB1_DATA = 64'h22;
   localparam logic [4:0]  WB2_RD   = 5'd5;
   localparam logic [63:0] WB2_DATA = 64'h11;
   localparam logic [31:0] BM_AFTER1 = 32'h0000_0020;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lr_writeback_sched_if #(.XLEN(XLEN)) bus();
   lr_writeback_sched #(.XLEN(XLEN), .OUTSTANDING(OUTSTANDING)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (bus)
   );

   int total = 0;
   int bad   = 0;

   // Model: pending set, per-unit in-flight lists, last writeback.
   bit              m_pend [32];
   int              q_md [$];
   int              q_lsu [$];
   bit              m_rr = 1'b0;
   bit              m_wbv = 1'b0;
   logic [4:0]      m_wbrd = '0;
   logic [XLEN-1:0] m_wbdata = '0;
   bit              exp_ir, exp_stall, g_md, g_lsu;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_comb();
      int inflight;
      inflight  = bus.issue_unit ? q_lsu.size() : q_md.size();
      exp_ir    = !rst && !m_pend[bus.issue_rd] && (inflight < OUTSTANDING);
      exp_stall = bus.id_valid && (m_pend[bus.id_rs1] || m_pend[bus.id_rs2]);
      g_md  = 1'b0;
      g_lsu = 1'b0;
      if (!rst && !bus.pipe_wb_busy) begin
         if (bus.md_done_valid && bus.lsu_done_valid) begin
`ifdef SB_ROUND_ROBIN_EN
            if (m_rr) g_lsu = 1'b1; else g_md = 1'b1;
`else
            g_lsu = 1'b1;
`endif
         end else begin
            g_md  = bus.md_done_valid;
            g_lsu = bus.lsu_done_valid;
         end
      end
   endtask

   task automatic check_outputs();
      logic [31:0] bm;
      model_comb();
      for (int i = 0; i < 32; i++) bm[i] = m_pend[i];
      chk("issue_ready", {63'd0, bus.issue_ready}, {63'd0, exp_ir});
      chk("sb_stall", {63'd0, bus.sb_stall}, {63'd0, exp_stall});
      chk("md_done_ready", {63'd0, bus.md_done_ready}, {63'd0, g_md});
      chk("lsu_done_ready", {63'd0, bus.lsu_done_ready}, {63'd0, g_lsu});
      chk("wb_valid", {63'd0, bus.wb_valid}, {63'd0, m_wbv});
      chk("wb_rd", {59'd0, bus.wb_rd}, {59'd0, m_wbrd});
      chk("wb_data", bus.wb_data, m_wbdata);
      chk("bitmap", {32'd0, bus.reg_write_bitmap}, {32'd0, bm});
   endtask

   // Applies one clock edge to the model; in-flight list length is the unit's count.
   task automatic model_update();
      bit acc;
      model_comb();
      acc = bus.issue_valid && exp_ir;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
         q_md.delete();
         q_lsu.delete();
         m_rr = 1'b0; m_wbv = 1'b0; m_wbrd = '0; m_wbdata = '0;
      end else begin
         if (m_wbv) m_pend[m_wbrd] = 1'b0;
         if (acc) begin
            if (bus.issue_rd != 0) m_pend[bus.issue_rd] = 1'b1;
            if (bus.issue_unit) q_lsu.push_back(int'(bus.issue_rd));
            else                q_md.push_back(int'(bus.issue_rd));
         end
         if (g_md) begin
            m_wbv = (bus.md_done_rd != 0); m_wbrd = bus.md_done_rd; m_wbdata = bus.md_done_data;
            if (q_md.size() > 0) void'(q_md.pop_front());
            m_rr = 1'b1;
         end else if (g_lsu) begin
            m_wbv = (bus.lsu_done_rd != 0); m_wbrd = bus.lsu_done_rd; m_wbdata = bus.lsu_done_data;
            if (q_lsu.size() > 0) void'(q_lsu.pop_front());
            m_rr = 1'b0;
         end else begin
            m_wbv = 1'b0;
         end
      end
   endtask

   task automatic settle();
      #1;
      check_outputs();
   endtask

   task automatic advance();
      bit was_rst;
      @(posedge clk);
      was_rst = rst;
      model_update();
      @(negedge clk);
      bus.issue_valid = 1'b0;
      if (g_md || was_rst)  bus.md_done_valid  = 1'b0;
      if (g_lsu || was_rst) bus.lsu_done_valid = 1'b0;
   endtask

   task automatic issue(input logic unit, input logic [4:0] rd);
      bus.issue_valid = 1'b1; bus.issue_unit = unit; bus.issue_rd = rd;
   endtask

   task automatic present_md(input logic [4:0] rd, input logic [XLEN-1:0] d);
      bus.md_done_valid = 1'b1; bus.md_done_rd = rd; bus.md_done_data = d;
   endtask

   task automatic present_lsu(input logic [4:0] rd, input logic [XLEN-1:0] d);
      bus.lsu_done_valid = 1'b1; bus.lsu_done_rd = rd; bus.lsu_done_data = d;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.issue_valid = 0; bus.issue_unit = 0; bus.issue_rd = 0;
      bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
      bus.md_done_valid = 0; bus.md_done_rd = 0; bus.md_done_data = 0;
      bus.lsu_done_valid = 0; bus.lsu_done_rd = 0; bus.lsu_done_data = 0;
      bus.pipe_wb_busy = 0;
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);

      issue(0, 5'd5); settle();
      chk("rst_issue_ready", {63'd0, bus.issue_ready}, 64'd0);
      chk("rst_bitmap", {32'd0, bus.reg_write_bitmap}, 64'd0);
      chk("rst_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
      advance();

      rst = 1'b0;
      issue(0, 5'd5); settle();
      chk("issue_md5", {63'd0, bus.issue_ready}, 64'd1);
      advance();
      bus.id_valid = 1; bus.id_rs1 = 5; bus.id_rs2 = 0; issue(1, 5'd5); settle();
      chk("bitmap_rd5", {32'd0, bus.reg_write_bitmap}, 64'h20);
      chk("stall_rs1_5", {63'd0, bus.sb_stall}, 64'd1);
      chk("waw_lsu5", {63'd0, bus.issue_ready}, 64'd0);
      bus.id_rs1 = 0; bus.id_rs2 = 6; issue(1, 5'd7); settle();
      chk("stall_none", {63'd0, bus.sb_stall}, 64'd0);
      chk("issue_lsu7", {63'd0, bus.issue_ready}, 64'd1);
      advance();
      bus.id_valid = 0;

      present_md(5'd5, 64'h11); present_lsu(5'd7, 64'h22); settle();
      chk("both_md_ready", {63'd0, bus.md_done_ready}, {63'd0, FIRST_MD});
      advance();
      settle();
      chk("wb1_valid", {63'd0, bus.wb_valid}, 64'd1);
      chk("wb1_rd", {59'd0, bus.wb_rd}, {59'd0, WB1_RD});
      chk("wb1_data", bus.wb_data, WB1_DATA);
      advance();
      settle();
      chk("wb2_rd", {59'd0, bus.wb_rd}, {59'd0, WB2_RD});
      chk("wb2_data", bus.wb_data, WB2_DATA);
      chk("bitmap_after_wb1", {32'd0, bus.reg_write_bitmap}, {32'd0, BM_AFTER1});
      advance();
      settle();
      chk("bitmap_after_wb2", {32'd0, bus.reg_write_bitmap}, 64'd0);
      advance();

      issue(0, 5'd9); settle(); advance();
      present_md(5'd9, 64'h99); bus.pipe_wb_busy = 1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("busy_md_ready", {63'd0, bus.md_done_ready}, 64'd0);
         chk("busy_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
         advance();
      end
      bus.pipe_wb_busy = 0; settle();
      chk("unbusy_grant", {63'd0, bus.md_done_ready}, 64'd1);
      advance();
      settle();
      chk("unbusy_wb_rd", {59'd0, bus.wb_rd}, 64'd9);
      advance();

      issue(0, 5'd1); settle(); advance();
      issue(0, 5'd2); settle();
      chk("issue_md2", {63'd0, bus.issue_ready}, 64'd1);
      advance();
      issue(0, 5'd3); settle();
      chk("full_refuse", {63'd0, bus.issue_ready}, 64'd0);
      advance();
      present_md(5'd1, 64'h1); issue(0, 5'd3); settle();
      chk("grant_cycle_full", {63'd0, bus.issue_ready}, 64'd0);
      advance();
      issue(0, 5'd3); settle();
      chk("freed_after_grant", {63'd0, bus.issue_ready}, 64'd1);
      advance();
      present_md(5'd2, 64'h2); settle(); advance();
      present_md(5'd3, 64'h3); settle(); advance();
      repeat (2) begin settle(); advance(); end

      issue(0, 5'd0); settle();
      chk("issue_x0", {63'd0, bus.issue_ready}, 64'd1);
      advance();
      settle();
      chk("bitmap_x0", {32'd0, bus.reg_write_bitmap}, 64'd0);
      present_md(5'd0, 64'h55); settle();
      chk("done_x0_ready", {63'd0, bus.md_done_ready}, 64'd1);
      advance();
      settle();
      chk("done_x0_no_wb", {63'd0, bus.wb_valid}, 64'd0);
      issue(0, 5'd10); settle();
      chk("cnt_freed_a", {63'd0, bus.issue_ready}, 64'd1);
      advance();
      issue(0, 5'd11); settle();
      chk("cnt_freed_b", {63'd0, bus.issue_ready}, 64'd1);
      advance();
      settle();
      chk("bitmap_10_11", {32'd0, bus.reg_write_bitmap}, 64'hC00);
      rst = 1'b1; settle(); advance();
      rst = 1'b0; settle();
      chk("midrst_bitmap", {32'd0, bus.reg_write_bitmap}, 64'd0);
      issue(0, 5'd12); settle(); advance();
      issue(0, 5'd13); settle();
      chk("midrst_cnt_zero", {63'd0, bus.issue_ready}, 64'd1);
      advance();

      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         if (rst) begin
            bus.md_done_valid = 0; bus.lsu_done_valid = 0;
         end else begin
            if ($urandom_range(0, 1) == 1)
               issue(1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 12)));
            if (!bus.md_done_valid && q_md.size() > 0 && $urandom_range(0, 1) == 1)
               present_md(5'(q_md[0]), {$urandom(), $urandom()});
            if (!bus.lsu_done_valid && q_lsu.size() > 0 && $urandom_range(0, 1) == 1)
               present_lsu(5'(q_lsu[0]), {$urandom(), $urandom()});
         end
         bus.id_valid = 1'($urandom_range(0, 1));
         bus.id_rs1 = 5'($urandom_range(0, 12));
         bus.id_rs2 = 5'($urandom_range(0, 12));
         bus.pipe_wb_busy = ($urandom_range(0, 3) == 0);
         settle();
         advance();
      end
      rst = 1'b0;
      settle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lr_writeback_sched.md
# lr_writeback_sched

Scoreboard and writeback scheduler for long-latency results (multiply/divide unit and load/store unit). It marks destination registers pending at issue, drives the pending bitmap consumed by the hazard unit, and stalls decode on RAW/WAW against pending registers. It also arbitrates the shared register-file write port between the two long-latency completers, yielding to the main pipeline writeback.

## Interface
Parameters:
- XLEN, 64, writeback data width
- OUTSTANDING, 2, max in-flight ops per unit (≥1); counter width $clog2(OUTSTANDING+1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  decode issuing a long-latency op
- issue_unit  in  1  0 = muldiv, 1 = lsu
- issue_rd  in  5  destination register
- issue_ready  out  1  issue accepted when issue_valid & issue_ready
- id_valid  in  1  decode holds a valid instruction
- id_rs1, id_rs2  in  5 each  decode source registers
- sb_stall  out  1  decode stall request
- md_done_valid  in  1  muldiv result available
- md_done_rd  in  5  muldiv result destination
- md_done_data  in  XLEN  muldiv result
- md_done_ready  out  1  muldiv result consumed
- lsu_done_valid  in  1  lsu result available
- lsu_done_rd  in  5  lsu result destination
- lsu_done_data  in  XLEN  lsu result
- lsu_done_ready  out  1  lsu result consumed
- pipe_wb_busy  in  1  main pipeline owns the write port this cycle
- wb_valid  out  1  register-file write enable (registered)
- wb_rd  out  5  write address (registered)
- wb_data  out  XLEN  write data (registered)
- reg_write_bitmap  out  32  pending bitmap; bit 0 always 0

## Operation
- State: pending[31:1], md_cnt, lsu_cnt, rr_ptr (0 = muldiv preferred), and the wb_* output registers.
- issue_ready (combinational) = ~rst & ~pending[issue_rd] & (selected unit's count < OUTSTANDING). rd = 0 never counts as pending.
- On accept: selected count +1; pending[issue_rd] set at the edge, unless rd = 0.
- sb_stall (combinational) = id_valid & (pending[id_rs1] | pending[id_rs2]); x0 is ignored.
- Arbitration (combinational) happens only when pipe_wb_busy = 0 and rst = 0.
  - One requester valid: that requester is granted.
  - Both valid: the requester selected by rr_ptr is granted.
  - done_ready = grant. After a grant, rr_ptr points to the other unit.
- Granted result: wb_valid <= (rd ≠ 0), wb_rd <= rd, wb_data <= data at the next edge. The granted unit's count is decremented at the same edge.
- No grant: wb_valid <= 0; wb_rd and wb_data hold their values.
- pending[wb_rd] clears at the edge ending a wb_valid = 1 cycle. The stall therefore persists through the write cycle, and decode reads the written value the cycle after.
- Simultaneous issue and completion on the same unit leave its count unchanged.
- An issue to an rd that is currently in the wb_valid cycle is refused, because the bit is still pending.

## Timing
- Reset (synchronous): pending = 0, counts = 0, rr_ptr = 0, wb_valid = 0, wb_rd = 0, wb_data = 0. issue_ready, md_done_ready and lsu_done_ready are forced to 0 while rst = 1.
- Reset mid-operation discards all in-flight tracking. The owning units are reset together.
- Latency:
  - issue → bitmap bit set: 1 cycle.
  - grant → wb_valid: 1 cycle.
  - wb_valid → bit cleared: 1 cycle.
  - A completion frees issue capacity the cycle after its grant, because issue_ready uses registered counts.
- Back-to-back grants are allowed every cycle. Throughput is 1 writeback/cycle when pipe_wb_busy = 0.
- A done_valid/rd/data triple must be held stable until its done_ready is asserted.

## Configuration
- SB_ROUND_ROBIN_EN defined: round-robin arbitration via rr_ptr, as described above.
- SB_ROUND_ROBIN_EN undefined: fixed priority, lsu over muldiv. rr_ptr is not implemented, and muldiv is granted only when lsu_done_valid = 0.

## Test plan
- Issue muldiv rd = 5 → issue_ready = 1; next cycle reg_write_bitmap = 0x0000_0020. With id_valid = 1 and id_rs1 = 5, sb_stall = 1. With id_rs1 = 0 and id_rs2 = 6, sb_stall = 0.
- WAW: with rd 5 pending, issue lsu rd = 5 → issue_ready = 0. Issue lsu rd = 7 → issue_ready = 1.
- Both done valid (md rd = 5, data 0x11; lsu rd = 7, data 0x22), pipe_wb_busy = 0, round-robin enabled, after reset:
  - Cycle +1: md granted, wb_valid = 1, wb_rd = 5, wb_data = 0x11.
  - Cycle +2: lsu granted, wb_rd = 7, wb_data = 0x22.
  - Bit 5 clears at cycle +2, bit 7 at cycle +3.
- pipe_wb_busy = 1 for 3 cycles with md_done_valid = 1 → md_done_ready = 0 and wb_valid = 0 throughout. The grant occurs in the first cycle after pipe_wb_busy drops.
- OUTSTANDING = 2:
  - Issue md rd 1, then rd 2. A third issue to rd 3 sees issue_ready = 0.
  - Complete rd 1 → issue_ready = 1 on the cycle after the grant.
- Done with rd = 0 → done_ready = 1, wb_valid stays 0, count decrements, bitmap unchanged. Assert rst with 2 ops pending → next cycle bitmap = 0 and counts = 0.
